// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings for the snake game blocks (controller, draw,
// collision checker). Game state, direction and collision code values live
// here so every block agrees on them.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PLAY      = 2'b01,
        ST_PAUSE     = 2'b10,
        ST_GAME_OVER = 2'b11
    } game_state_t;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'b000,
        DIR_UP    = 3'b001,
        DIR_DOWN  = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_RIGHT = 3'b100
    } dir_t;

    localparam logic [1:0] COLL_NONE  = 2'b00;
    localparam logic [1:0] COLL_WALL  = 2'b01;
    localparam logic [1:0] COLL_APPLE = 2'b10;
    localparam logic [1:0] COLL_SELF  = 2'b11;

    // Direction that would make the snake reverse onto itself.
    function automatic dir_t opposite_dir(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_IDLE;
        endcase
    endfunction

    // Highest-priority pressed button: UP > DOWN > LEFT > RIGHT.
    function automatic dir_t button_dir(input logic up, input logic down,
                                        input logic left, input logic right);
        if (up)         return DIR_UP;
        else if (down)  return DIR_DOWN;
        else if (left)  return DIR_LEFT;
        else if (right) return DIR_RIGHT;
        else            return DIR_IDLE;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: counts video frames and raises o_tick on the frame that
// completes one move period. The period shrinks by one on each speedup
// request, never below MIN_TICK_FRAMES.
import snake_pkg::*;

module snake_tick_gen #(
    parameter int TICK_FRAMES     = 8,
    parameter int MIN_TICK_FRAMES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    input  logic i_speedup,
    input  logic i_frame_start,
    output logic o_tick
);

    localparam logic [7:0] PERIOD_INIT = 8'(TICK_FRAMES);
    localparam logic [7:0] PERIOD_MIN  = 8'(MIN_TICK_FRAMES);

    logic [7:0] r_count;
    logic [7:0] r_period;
    logic       w_last;

    // ">=" rather than "==": a speedup can drop the period below a count
    // already reached, and that count must still complete on its next frame.
    assign w_last = (r_count >= (r_period - 8'd1));
    assign o_tick = i_enable & i_frame_start & w_last;

    // Frame counter and move period; the new period applies to the next count.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count  <= 8'd0;
            r_period <= PERIOD_INIT;
        end else begin
            if (i_enable && i_frame_start) begin
                r_count <= w_last ? 8'd0 : (r_count + 8'd1);
            end
            if (i_speedup && (r_period > PERIOD_MIN)) begin
                r_period <= r_period - 8'd1;
            end
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game sequencer. Owns the IDLE/PLAY/(PAUSE)/GAME_OVER state
// machine, turns frame ticks into a one-cycle move strobe, commits player
// turns with reversal rejection, scores apples and ends the game on a wall or
// self hit. Optional pause support is compiled in with SNAKE_PAUSE_EN.
// Handshake: there is none; o_update is a single-cycle strobe and all other
// outputs are levels, all registered, valid every cycle.
import snake_pkg::*;

module snake_game_ctrl #(
    parameter int TICK_FRAMES      = 8,
    parameter int MIN_TICK_FRAMES  = 2,
    parameter int GAME_OVER_FRAMES = 120
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_start,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_left,
    input  logic       i_btn_right,
    input  logic       i_btn_start,
    input  logic [1:0] i_collision,
    output logic [1:0] o_game_state,
    output logic [2:0] o_direction,
    output logic       o_update,
    output logic [7:0] o_score
);

    localparam logic [7:0] GO_LAST = 8'(GAME_OVER_FRAMES - 1);

    game_state_t r_state;
    game_state_t w_next_state;
    dir_t        r_direction;
    dir_t        r_pending_dir;
    dir_t        w_btn_dir;
    logic        r_start_d;
    logic        r_apple_d;
    logic        r_update;
    logic [7:0]  r_score;
    logic [7:0]  r_go_count;

    logic w_start_edge;
    logic w_apple_edge;
    logic w_fatal;
    logic w_play_entry;
    logic w_run;
    logic w_tick;
    logic w_speedup;
    logic w_go_done;

    assign w_start_edge = i_btn_start & ~r_start_d;
    assign w_apple_edge = (i_collision == COLL_APPLE) & ~r_apple_d;
    assign w_fatal      = (i_collision == COLL_WALL) | (i_collision == COLL_SELF);
    assign w_btn_dir    = button_dir(i_btn_up, i_btn_down, i_btn_left, i_btn_right);
    assign w_speedup    = (r_state == ST_PLAY) & w_apple_edge;
    assign w_go_done    = (r_state == ST_GAME_OVER) & i_frame_start & (r_go_count == GO_LAST);

    // w_run gates the frame counter, so a move due in a cycle that leaves
    // PLAY (fatal hit or pause) is dropped and the count stays frozen.
    snake_tick_gen #(
        .TICK_FRAMES     (TICK_FRAMES),
        .MIN_TICK_FRAMES (MIN_TICK_FRAMES)
    ) u_tick_gen (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enable      (w_run),
        .i_clear       (w_play_entry),
        .i_speedup     (w_speedup),
        .i_frame_start (i_frame_start),
        .o_tick        (w_tick)
    );

    // Next-state decode plus the PLAY-entry and run strobes.
    always_comb begin
        w_next_state = r_state;
        w_play_entry = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_next_state = ST_PLAY;
                    w_play_entry = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_fatal) begin
                    w_next_state = ST_GAME_OVER;
                end
`ifdef SNAKE_PAUSE_EN
                else if (w_start_edge) begin
                    w_next_state = ST_PAUSE;
                end
`endif
                else begin
                    w_run = 1'b1;
                end
            end
`ifdef SNAKE_PAUSE_EN
            ST_PAUSE: begin
                if (w_start_edge) begin
                    w_next_state = ST_PLAY;
                end
            end
`endif
            ST_GAME_OVER: begin
                if (w_go_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Edge-detector history for the start button and the apple code.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_start_d <= 1'b0;
            r_apple_d <= 1'b0;
        end else begin
            r_start_d <= i_btn_start;
            r_apple_d <= (i_collision == COLL_APPLE);
        end
    end

    // Frames spent in GAME_OVER; restarts from zero on every entry.
    always_ff @(posedge i_clk) begin
        if (i_reset || (r_state != ST_GAME_OVER)) r_go_count <= 8'd0;
        else if (i_frame_start)                   r_go_count <= r_go_count + 8'd1;
    end

    // Pending turn: latest non-reversing button press; a new game starts stationary.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_play_entry) begin
            r_pending_dir <= DIR_IDLE;
        end else if ((r_state == ST_PLAY) && (w_btn_dir != DIR_IDLE) &&
                     (w_btn_dir != opposite_dir(r_direction))) begin
            r_pending_dir <= w_btn_dir;
        end
    end

    // Committed direction: takes the pending turn together with each move.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_play_entry || w_go_done) r_direction <= DIR_IDLE;
        else if (w_tick)                          r_direction <= r_pending_dir;
    end

    // Move strobe, one cycle after the completing frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_update <= 1'b0;
        else         r_update <= w_tick;
    end

    // Score: cleared on a new game, one per apple edge, saturating.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_play_entry) begin
            r_score <= 8'd0;
        end else if (w_speedup && (r_score != 8'hFF)) begin
            r_score <= r_score + 8'd1;
        end
    end

    assign o_game_state = r_state;
    assign o_direction  = r_direction;
    assign o_update     = r_update;
    assign o_score      = r_score;

endmodule
